pulse_record_arbiter: RTL
=========================

# pulse_record_arbiter

Shares the single ARM-facing record RAM between the I-channel and Q-channel pulse detectors, sitting between the detection datapath and the dual-port RAM the ARM reads. It grants one detector at a time by round-robin, writes a header word plus that detector's payload burst into a ring of fixed-size record slots, and tracks slot occupancy against ARM acknowledgements. Everything runs in the ADC clock domain.

## Interface
- ADDR_W, 11, RAM word-address width (2^ADDR_W words).
- REC_WORDS, 64, words per record slot (power of two, ≥2); slot count NSLOT = 2^ADDR_W / REC_WORDS.
- SLOT_W, ADDR_W − log2(REC_WORDS), slot index width (derived).

- adc_clk  in  1  sole clock.
- adc_rst_n  in  1  asynchronous, active-low reset.
- en  in  1  when 0, no new grants; an in-flight record completes.
- req_i / req_q  in  1  detector holds high until granted.
- gnt_i / gnt_q  out  1  one-cycle grant pulse.
- dvld_i / dvld_q  in  1  payload word valid; honoured only from the current owner.
- dat_i / dat_q  in  32  payload word.
- ram_addra  out  ADDR_W  RAM word address.
- ram_wea  out  1  RAM write enable.
- ram_dina  out  32  RAM write data.
- arm_ack  in  1  one-cycle pulse: ARM has consumed the oldest slot.
- rec_pending  out  1  rec_count ≠ 0.
- rec_count  out  SLOT_W+1  occupied slots.
- full  out  1  rec_count == NSLOT.
- rd_slot  out  SLOT_W  oldest unread slot index.

## Operation
- States: IDLE, HDR, BURST, COMMIT.
- IDLE: if en & !full & (req_i | req_q), choose the owner by round-robin. A single requester wins outright. With both requesting, the channel not served last wins; after reset the I channel has priority. Go to HDR.
- HDR (1 cycle): gnt_owner = 1. Write the header at wr_slot·REC_WORDS as {owner (0=I, 1=Q), 15'd0, seq[15:0]}. Go to BURST with offset = 1.
- BURST: each owner dvld writes the owner's dat at wr_slot·REC_WORDS + offset, then offset++. After the write at offset REC_WORDS−1, go to COMMIT. Non-owner dvld and data are ignored. There is no timeout; a stalled owner holds the arbiter.
- COMMIT (1 cycle): wr_slot++ (wraps at NSLOT), seq++ (wraps at 2^16), count++, last-served ← owner. Return to IDLE.
- arm_ack: if count ≠ 0, rd_slot++ (wraps) and count−−. If count == 0, arm_ack is ignored.
- If COMMIT and a valid arm_ack fall in the same cycle, count is unchanged while both pointers advance.
- full blocks new grants only. The in-flight record was granted with a free slot, so it always completes.
- Requests are not queued or counted while blocked; the detector keeps req high.
- Reset mid-burst returns to IDLE and clears pointers, count and seq. The partially written slot is abandoned and is not readable because count = 0.

## Timing
- Reset values: gnt_* = 0, ram_wea = 0, ram_addra = 0, ram_dina = 0, rec_pending = 0, rec_count = 0, full = 0, rd_slot = 0. Internally: wr_slot = 0, seq = 0, state = IDLE, priority = I.
- All outputs are registered.
- Request seen in IDLE at cycle N: gnt and the header write both appear at N+1.
- dvld from the owner is accepted from N+2 onward. dvld at cycle M produces the RAM write at M+1.
- Last payload dvld at cycle M: write at M+1, COMMIT at M+1. rec_count and rd-visible state update at M+2. IDLE can re-arbitrate at M+2, so the next gnt is at M+3 at the earliest.
- Minimum record time is REC_WORDS + 2 cycles.
- arm_ack effect is visible on rec_count and rd_slot the next cycle.

## Structure
- Package pd_pkg holds:
  - the REC_WORDS and ADDR_W defaults;
  - the header field positions (channel bit 31, seq bits 15:0);
  - the channel-id constants CH_I = 0 and CH_Q = 1;
  - the state enum.
- Sub-module pd_rr_arb: 2-way round-robin picker. Inputs: req pair, last-served and an update strobe. Output: grant index.
- The FSM, pointers and RAM mux live in the top.

## Test plan
- Reset, then req_i alone, 63 dvld words 0x100..0x13E → header 0x00000000 at addr 0; payloads at 1..63; rec_count = 1; gnt_i single pulse.
- req_i and req_q held together for 4 records → owners I, Q, I, Q. Headers at slots 0–3 carry seq 0–3 and channel bits 0, 1, 0, 1.
- Fill 32 slots with no ack → full = 1. A pending req_q gets no grant. One arm_ack → full drops, and gnt_q follows 2 cycles later.
- arm_ack pulsed in the COMMIT cycle with count = 5 → rec_count stays 5, rd_slot +1. arm_ack at count 0 → no change.
- en dropped mid-burst → record completes and commits, and no further gnt occurs while en = 0. Non-owner dvld during the burst causes no RAM write.
- adc_rst_n asserted at payload offset 30 → all outputs take their reset values asynchronously, and the next record writes slot 0 with seq 0.

Source files
------------

// File: rtl/pd_pkg.sv
// Shared constants, header layout and FSM state type for the pulse record arbiter.
package pd_pkg;

  localparam int ADDR_W_DEF    = 11;
  localparam int REC_WORDS_DEF = 64;

  localparam int HDR_CH_BIT  = 31;
  localparam int HDR_SEQ_MSB = 15;

  localparam logic CH_I = 1'b0;
  localparam logic CH_Q = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HDR    = 2'd1,
    ST_BURST  = 2'd2,
    ST_COMMIT = 2'd3
  } pd_state_e;

  function automatic logic [31:0] make_header(input logic ch, input logic [15:0] seq);
    logic [31:0] h;
    h                  = 32'd0;
    h[HDR_CH_BIT]      = ch;
    h[HDR_SEQ_MSB:0]   = seq;
    return h;
  endfunction

endpackage

// File: rtl/pd_rr_arb.sv
// Two-way round-robin picker: on a tie the channel not served last wins; I wins first after reset.
module pd_rr_arb
  import pd_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic req_q,
  input  logic last_served,
  input  logic upd,
  output logic gnt_idx
);

  logic last_r;

  // Remember which channel completed the most recent record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= CH_Q;
    end else if (upd) begin
      last_r <= last_served;
    end else begin
      last_r <= last_r;
    end
  end

  // Pick a winner from the current requests.
  always_comb begin
    gnt_idx = CH_I;
    if (req_i && req_q) begin
      gnt_idx = ~last_r;
    end else if (req_q) begin
      gnt_idx = CH_Q;
    end else begin
      gnt_idx = CH_I;
    end
  end

endmodule

// File: rtl/pulse_record_arbiter.sv
// Arbitrates the I/Q pulse detectors onto one record RAM, writing header plus payload into
// a ring of fixed-size slots and tracking occupancy against ARM acknowledgements.
module pulse_record_arbiter
  import pd_pkg::*;
#(
  parameter int  ADDR_W    = ADDR_W_DEF,
  parameter int  REC_WORDS = REC_WORDS_DEF,
  localparam int SLOT_W    = ADDR_W - $clog2(REC_WORDS)
) (
  input  logic              adc_clk,
  input  logic              adc_rst_n,
  input  logic              en,
  input  logic              req_i,
  input  logic              req_q,
  output logic              gnt_i,
  output logic              gnt_q,
  input  logic              dvld_i,
  input  logic              dvld_q,
  input  logic [31:0]       dat_i,
  input  logic [31:0]       dat_q,
  output logic [ADDR_W-1:0] ram_addra,
  output logic              ram_wea,
  output logic [31:0]       ram_dina,
  input  logic              arm_ack,
  output logic              rec_pending,
  output logic [SLOT_W:0]   rec_count,
  output logic              full,
  output logic [SLOT_W-1:0] rd_slot
);

  localparam int                OFF_W    = $clog2(REC_WORDS);
  localparam logic [OFF_W-1:0]  OFF_LAST = OFF_W'(REC_WORDS - 1);
  localparam logic [SLOT_W:0]   NSLOT    = {1'b1, {SLOT_W{1'b0}}};

  pd_state_e         state_r, state_nxt_s;
  logic              owner_r, owner_nxt_s;
  logic [OFF_W-1:0]  off_r, off_nxt_s;
  logic [SLOT_W-1:0] wr_slot_r, wr_slot_nxt_s, rd_slot_nxt_s;
  logic [15:0]       seq_r, seq_nxt_s;
  logic [SLOT_W:0]   count_nxt_s;
  logic              gnt_i_nxt_s, gnt_q_nxt_s, wea_nxt_s;
  logic [ADDR_W-1:0] addr_nxt_s;
  logic [31:0]       din_nxt_s;
  logic              commit_s, ack_ok_s, pick_s, own_vld_s;
  logic [31:0]       own_dat_s;

  pd_rr_arb u_arb (
    .clk         (adc_clk),
    .rst_n       (adc_rst_n),
    .req_i       (req_i),
    .req_q       (req_q),
    .last_served (owner_r),
    .upd         (commit_s),
    .gnt_idx     (pick_s)
  );

  assign own_vld_s = (owner_r == CH_Q) ? dvld_q : dvld_i;
  assign own_dat_s = (owner_r == CH_Q) ? dat_q  : dat_i;

  // Record FSM: decides the next state and the next RAM write / grant pulse.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    off_nxt_s   = off_r;
    gnt_i_nxt_s = 1'b0;
    gnt_q_nxt_s = 1'b0;
    wea_nxt_s   = 1'b0;
    addr_nxt_s  = {ADDR_W{1'b0}};
    din_nxt_s   = 32'd0;
    commit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en && !full && (req_i || req_q)) begin
          state_nxt_s = ST_HDR;
          owner_nxt_s = pick_s;
          gnt_i_nxt_s = (pick_s == CH_I);
          gnt_q_nxt_s = (pick_s == CH_Q);
          wea_nxt_s   = 1'b1;
          addr_nxt_s  = {wr_slot_r, {OFF_W{1'b0}}};
          din_nxt_s   = make_header(pick_s, seq_r);
          off_nxt_s   = OFF_W'(1);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        state_nxt_s = ST_BURST;
      end
      ST_BURST: begin
        if (own_vld_s) begin
          wea_nxt_s  = 1'b1;
          addr_nxt_s = {wr_slot_r, off_r};
          din_nxt_s  = own_dat_s;
          off_nxt_s  = off_r + OFF_W'(1);
          if (off_r == OFF_LAST) begin
            state_nxt_s = ST_COMMIT;
          end else begin
            state_nxt_s = ST_BURST;
          end
        end else begin
          state_nxt_s = ST_BURST;
        end
      end
      ST_COMMIT: begin
        commit_s    = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Ring pointers and occupancy; a commit and a valid ack together leave the count unchanged.
  always_comb begin
    ack_ok_s      = arm_ack && (rec_count != {(SLOT_W+1){1'b0}});
    wr_slot_nxt_s = commit_s ? (wr_slot_r + SLOT_W'(1)) : wr_slot_r;
    seq_nxt_s     = commit_s ? (seq_r + 16'd1) : seq_r;
    rd_slot_nxt_s = ack_ok_s ? (rd_slot + SLOT_W'(1)) : rd_slot;
    case ({commit_s, ack_ok_s})
      2'b10:   count_nxt_s = rec_count + (SLOT_W+1)'(1);
      2'b01:   count_nxt_s = rec_count - (SLOT_W+1)'(1);
      default: count_nxt_s = rec_count;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      state_r     <= ST_IDLE;
      owner_r     <= CH_I;
      off_r       <= {OFF_W{1'b0}};
      wr_slot_r   <= {SLOT_W{1'b0}};
      seq_r       <= 16'd0;
      gnt_i       <= 1'b0;
      gnt_q       <= 1'b0;
      ram_wea     <= 1'b0;
      ram_addra   <= {ADDR_W{1'b0}};
      ram_dina    <= 32'd0;
      rec_count   <= {(SLOT_W+1){1'b0}};
      rec_pending <= 1'b0;
      full        <= 1'b0;
      rd_slot     <= {SLOT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      owner_r     <= owner_nxt_s;
      off_r       <= off_nxt_s;
      wr_slot_r   <= wr_slot_nxt_s;
      seq_r       <= seq_nxt_s;
      gnt_i       <= gnt_i_nxt_s;
      gnt_q       <= gnt_q_nxt_s;
      ram_wea     <= wea_nxt_s;
      ram_addra   <= addr_nxt_s;
      ram_dina    <= din_nxt_s;
      rec_count   <= count_nxt_s;
      rec_pending <= (count_nxt_s != {(SLOT_W+1){1'b0}});
      full        <= (count_nxt_s == NSLOT);
      rd_slot     <= rd_slot_nxt_s;
    end
  end

endmodule
